// File: rtl/edge_event_counter.sv
// Edge event counter: synchronises an asynchronous event input, detects a selectable
// edge and counts up/down with wrap or saturate, clear, load, compare match and sticky overflow.
module edge_event_counter #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             signal,
    input  logic             enable,
    input  logic [1:0]       edge_sel,
    input  logic             up_down,
    input  logic             wrap_en,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] compare_value,
    input  logic             ovf_clear,
    output logic [WIDTH-1:0] count,
    output logic             event_pulse,
    output logic             match,
    output logic             overflow
);

    localparam int ARM_CYCLES = SYNC_STAGES + 1;
    localparam int ARM_W      = $clog2(ARM_CYCLES + 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] w_sync_d;
    logic                   r_prev;
    logic [ARM_W-1:0]       r_arm_cnt;
    logic [WIDTH-1:0]       r_count;
    logic [WIDTH-1:0]       w_count_next;
    logic                   r_event_pulse;
    logic                   r_overflow;

    logic w_armed;
    logic w_rise;
    logic w_fall;
    logic w_edge_hit;
    logic w_event;
    logic w_at_limit;
    logic w_ovf_set;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign w_sync_d[gi] = signal;
            end else begin : g_rest
                assign w_sync_d[gi] = r_sync[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= w_sync_d;
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    // Edges are ignored until the chain has been refilled with real samples after reset.
    assign w_armed = (r_arm_cnt == ARM_W'(ARM_CYCLES));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_arm_cnt <= '0;
        end else if (!w_armed) begin
            r_arm_cnt <= r_arm_cnt + ARM_W'(1);
        end
    end

    assign w_rise = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign w_fall = ~r_sync[SYNC_STAGES-1] & r_prev;

    always_comb begin
        w_edge_hit = 1'b0;
        case (edge_sel)
            2'b00:   w_edge_hit = w_rise;
            2'b01:   w_edge_hit = w_fall;
            2'b10:   w_edge_hit = w_rise | w_fall;
            default: w_edge_hit = 1'b0;
        endcase
    end

    assign w_event    = w_armed & w_edge_hit & enable;
    assign w_at_limit = up_down ? (r_count == {WIDTH{1'b1}}) : (r_count == '0);
    assign w_ovf_set  = w_event & w_at_limit & ~clear & ~load;

    always_comb begin
        w_count_next = r_count;
        if (clear) begin
            w_count_next = '0;
        end else if (load) begin
            w_count_next = load_value;
        end else if (w_event) begin
            if (up_down) begin
                if (w_at_limit) begin
                    w_count_next = wrap_en ? '0 : {WIDTH{1'b1}};
                end else begin
                    w_count_next = r_count + WIDTH'(1);
                end
            end else begin
                if (w_at_limit) begin
                    w_count_next = wrap_en ? {WIDTH{1'b1}} : '0;
                end else begin
                    w_count_next = r_count - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count       <= '0;
            r_event_pulse <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_count       <= w_count_next;
            r_event_pulse <= w_event;
            // Setting takes precedence so a limit hit is never lost to a concurrent clear.
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (ovf_clear) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign count       = r_count;
    assign event_pulse = r_event_pulse;
    assign overflow    = r_overflow;
    assign match       = (r_count == compare_value);

endmodule

// File: tb/tb_edge_event_counter.sv
// Randomised and directed bench for edge_event_counter (WIDTH=4, SYNC_STAGES=2) against
// a sample-history reference model of the event rules.
module tb_edge_event_counter;

    localparam int W    = 4;
    localparam int N    = 2;
    localparam int MAXV = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         signal;
    logic         enable;
    logic [1:0]   edge_sel;
    logic         up_down;
    logic         wrap_en;
    logic         clear;
    logic         load;
    logic [W-1:0] load_value;
    logic [W-1:0] compare_value;
    logic         ovf_clear;
    logic [W-1:0] count;
    logic         event_pulse;
    logic         match;
    logic         overflow;

    edge_event_counter #(.WIDTH(W), .SYNC_STAGES(N)) dut (
        .clk(clk), .reset(reset), .signal(signal), .enable(enable),
        .edge_sel(edge_sel), .up_down(up_down), .wrap_en(wrap_en),
        .clear(clear), .load(load), .load_value(load_value),
        .compare_value(compare_value), .ovf_clear(ovf_clear),
        .count(count), .event_pulse(event_pulse), .match(match), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_passed = 0;
    int pulses_seen = 0;

    // Model state: hist[0] is the signal value sampled at the most recent clock edge.
    int m_cnt   = 0;
    int m_ovf   = 0;
    int m_pulse = 0;
    int m_edges = 0;
    int hist[$];

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        m_cnt = 0; m_ovf = 0; m_pulse = 0; m_edges = 0;
        hist.delete();
    endtask

    task automatic model_edge();
        int  s_new, s_old;
        bit  rise, fall, hit, ev, lim;
        // The detector compares the samples taken N and N+1 edges ago.
        s_new = (hist.size() >= N)     ? hist[N-1] : 0;
        s_old = (hist.size() >= N + 1) ? hist[N]   : 0;
        rise  = (s_new == 1) && (s_old == 0);
        fall  = (s_new == 0) && (s_old == 1);
        case (edge_sel)
            2'd0:    hit = rise;
            2'd1:    hit = fall;
            2'd2:    hit = rise || fall;
            default: hit = 1'b0;
        endcase
        ev  = (m_edges >= N + 1) && hit && enable;
        lim = up_down ? (m_cnt == MAXV) : (m_cnt == 0);
        hist.push_front(int'(signal));
        if (hist.size() > 8) void'(hist.pop_back());
        if (m_edges < 100) m_edges++;
        m_pulse = ev;
        if (ev && !clear && !load && lim) m_ovf = 1;
        else if (ovf_clear) m_ovf = 0;
        if (clear) m_cnt = 0;
        else if (load) m_cnt = int'(load_value);
        else if (ev) begin
            if (up_down) m_cnt = lim ? (wrap_en ? 0 : MAXV) : m_cnt + 1;
            else         m_cnt = lim ? (wrap_en ? MAXV : 0) : m_cnt - 1;
        end
    endtask

    task automatic check_all();
        check_val("count", int'(count), m_cnt);
        check_val("event_pulse", int'(event_pulse), m_pulse);
        check_val("overflow", int'(overflow), m_ovf);
        check_val("match", int'(match), int'(m_cnt == int'(compare_value)));
    endtask

    // One clock: inputs are set by the caller at the falling edge before calling.
    task automatic cyc();
        @(posedge clk);
        if (!reset) model_reset();
        else model_edge();
        #1;
        check_all();
        if (event_pulse) pulses_seen++;
        @(negedge clk);
    endtask

    task automatic pulse_sig();
        signal = 1'b1; repeat (2) cyc();
        signal = 1'b0; repeat (2) cyc();
    endtask

    task automatic settle_and_clear();
        signal = 1'b0; repeat (4) cyc();
        clear = 1'b1; cyc(); clear = 1'b0;
    endtask

    initial begin
        int exp_sel[4];
        int exp_wrap[3];
        int exp_sat[3];
        int exp_down[3];
        exp_sel  = '{4, 4, 8, 0};
        exp_wrap = '{15, 0, 1};
        exp_sat  = '{15, 15, 15};
        exp_down = '{1, 0, 15};

        reset = 1'b0; signal = 1'b1; enable = 1'b1; edge_sel = 2'd0;
        up_down = 1'b1; wrap_en = 1'b1; clear = 1'b0; load = 1'b0;
        load_value = '0; compare_value = 4'd5; ovf_clear = 1'b0;
        model_reset();
        @(negedge clk);
        repeat (3) cyc();

        // Reset and arming with signal held high
        reset = 1'b1;
        pulses_seen = 0;
        repeat (10) cyc();
        check_val("arm_count", int'(count), 0);
        check_val("arm_pulses", pulses_seen, 0);
        signal = 1'b0; repeat (3) cyc();
        signal = 1'b1; cyc(); cyc();
        check_val("latency_early", int'(count), 0);
        cyc();
        check_val("latency_count", int'(count), 1);

        // Edge select with 4 full pulses
        for (int sel = 0; sel < 4; sel++) begin
            edge_sel = 2'(sel);
            settle_and_clear();
            pulses_seen = 0;
            repeat (4) pulse_sig();
            repeat (4) cyc();
            check_val($sformatf("edge_sel%0d_count", sel), int'(count), exp_sel[sel]);
            check_val($sformatf("edge_sel%0d_pulses", sel), pulses_seen, exp_sel[sel]);
        end

        // Wrap then saturate from 14, counting up
        edge_sel = 2'd0; up_down = 1'b1;
        for (int mode = 0; mode < 2; mode++) begin
            wrap_en = (mode == 0);
            settle_and_clear();
            ovf_clear = 1'b1; load = 1'b1; load_value = 4'd14; cyc();
            ovf_clear = 1'b0; load = 1'b0;
            check_val("ovf_cleared", int'(overflow), 0);
            for (int i = 0; i < 3; i++) begin
                pulse_sig();
                check_val(mode == 0 ? "wrap_seq" : "sat_seq", int'(count),
                          mode == 0 ? exp_wrap[i] : exp_sat[i]);
            end
            check_val("limit_ovf", int'(overflow), 1);
        end
        ovf_clear = 1'b1; cyc(); ovf_clear = 1'b0;
        check_val("ovf_clear", int'(overflow), 0);

        // Down count through zero with wrap
        wrap_en = 1'b1; up_down = 1'b0;
        load = 1'b1; load_value = 4'd2; cyc(); load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pulse_sig();
            check_val("down_seq", int'(count), exp_down[i]);
            check_val("down_ovf", int'(overflow), i == 2 ? 1 : 0);
        end

        // Priority of clear/load over a qualified event, then load over event
        up_down = 1'b1; edge_sel = 2'd2;
        signal = 1'b0; repeat (4) cyc();
        signal = 1'b1; cyc();
        signal = 1'b0; cyc();
        clear = 1'b1; load = 1'b1; load_value = 4'd9; cyc();
        check_val("prio_clear_count", int'(count), 0);
        check_val("prio_clear_pulse", int'(event_pulse), 1);
        clear = 1'b0; cyc();
        check_val("prio_load_count", int'(count), 9);
        check_val("prio_load_pulse", int'(event_pulse), 1);
        load = 1'b1; load_value = 4'd15; ovf_clear = 1'b1; cyc();
        load = 1'b0; ovf_clear = 1'b0;
        signal = 1'b1; cyc(); cyc();
        ovf_clear = 1'b1; cyc(); ovf_clear = 1'b0;
        check_val("ovf_set_wins", int'(overflow), 1);
        check_val("ovf_wrap_count", int'(count), 0);

        // Match while counting 0..6, then asynchronous reset mid-cycle
        edge_sel = 2'd0; compare_value = 4'd5;
        settle_and_clear();
        repeat (6) pulse_sig();
        check_val("match_count6", int'(count), 6);
        check_val("match_at6", int'(match), 0);
        @(posedge clk);
        model_edge();
        #3 reset = 1'b0;
        #1 model_reset();
        check_val("async_count", int'(count), 0);
        check_val("async_pulse", int'(event_pulse), 0);
        compare_value = 4'd0;
        #1 check_val("reset_match", int'(match), 1);
        @(negedge clk);
        cyc();
        reset = 1'b1;

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 35) signal = ~signal;
            enable    = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) edge_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) up_down  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) wrap_en  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 49) == 0) compare_value = 4'($urandom_range(0, MAXV));
            clear      = ($urandom_range(0, 99) < 3);
            load       = ($urandom_range(0, 99) < 5);
            load_value = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, MAXV))
                                                     : (($urandom_range(0, 1) != 0) ? 4'd15 : 4'd0);
            ovf_clear  = ($urandom_range(0, 99) < 10);
            reset      = ($urandom_range(0, 399) != 0);
            cyc();
        end
        reset = 1'b1; clear = 1'b0; load = 1'b0; ovf_clear = 1'b0;
        repeat (4) cyc();

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule

// File: doc/edge_event_counter.md
# edge_event_counter

Parametrised event counter that replaces the single-purpose 16-bit edge counter in the measurement datapath. It synchronises an asynchronous event input into the `clk` domain and detects a selectable edge type. It then counts up or down with wrap or saturate, and supports synchronous clear, parallel load, a compare-match output and a sticky overflow flag. It feeds the status/readback logic and any block that needs event totals or threshold detection.

## Interface
- `WIDTH`, 16: counter width in bits; legal range 2–32.
- `SYNC_STAGES`, 2: synchroniser depth on `signal`; legal range 2–4.

- `clk`  in  1: system clock; all state updates on rising edge.
- `reset`  in  1: asynchronous, active-low.
- `signal`  in  1: asynchronous event input.
- `enable`  in  1: 1 = qualified events modify `count`.
- `edge_sel`  in  2: event edge select.
  - 00: rising.
  - 01: falling.
  - 10: both.
  - 11: none.
- `up_down`  in  1: 1 = count up, 0 = count down.
- `wrap_en`  in  1: 1 = wrap at limits, 0 = saturate at limits.
- `clear`  in  1: synchronous clear of `count`.
- `load`  in  1: synchronous load of `load_value`.
- `load_value`  in  WIDTH: parallel load data.
- `compare_value`  in  WIDTH: match threshold.
- `ovf_clear`  in  1: clears `overflow`.
- `count`  out  WIDTH: registered counter value.
- `event_pulse`  out  1: registered one-cycle pulse per qualified event.
- `match`  out  1: `count == compare_value`; combinational from the `count` register.
- `overflow`  out  1: sticky limit-crossing flag.

## Operation
- Synchroniser and edge detect:
  - `signal` passes through `SYNC_STAGES` flops, `s[0]` to `s[N-1]`, then one history flop `p`.
  - Rising edge = `s[N-1] & ~p`. Falling edge = `~s[N-1] & p`.
- Arm counter: after `reset` deasserts, edge detection is masked for the first `SYNC_STAGES+1` clk edges. This stops the reset value of the chain from producing a false edge.
- Qualified event = armed & edge matches `edge_sel` & `enable`.
- `count` update priority per cycle:
  1. `clear`: `count` = 0.
  2. `load`: `count` = `load_value`.
  3. Qualified event: `count` increments or decrements.
  4. Otherwise: hold.
- Limits:
  - Up at all-ones: with `wrap_en`=1 go to 0; with `wrap_en`=0 hold all-ones.
  - Down at 0: with `wrap_en`=1 go to all-ones; with `wrap_en`=0 hold 0.
- Arithmetic is modulo 2^WIDTH; no carry out beyond `overflow`.
- `overflow` is set by any qualified event at a limit, in either wrap or saturate mode, provided that event is not overridden by `clear` or `load`.
- `overflow` is cleared by `ovf_clear`. If set and `ovf_clear` occur in the same cycle, set wins.
- `event_pulse` goes high for every qualified event, including when saturated and when overridden by `clear`/`load`.
- `edge_sel`, `up_down` and `wrap_en` may change on any cycle; they take effect on the next qualified event.

## Timing
- Reset values:
  - `count` = 0.
  - `event_pulse` = 0.
  - `overflow` = 0.
  - `match` = (`compare_value` == 0).
  - Sync chain and `p` = 0; arm counter = 0.
- Latency: a `signal` transition captured by `s[0]` at edge k changes `count` at edge k+SYNC_STAGES. `event_pulse` is high during the cycle after that same edge. With the default of 2 stages this is 3 clk edges from signal to visible count.
- `clear`/`load` act at the next rising `clk`; the new `count` is visible in the following cycle.
- `match` follows `count` with zero additional latency.
- `signal` minimum high and low width: 2 clk periods for guaranteed detection. Shorter pulses may be lost; no metastability propagates.
- `reset` asserted mid-operation: all state returns to reset values immediately (asynchronous) and the arm counter restarts. Deassertion must be synchronised externally to `clk`.

## Test plan
- Reset and arming: hold `signal`=1 through reset, release, `edge_sel`=00 → `count` stays 0 and no `event_pulse` for 10 cycles; a later rising edge gives `count`=1 three edges after capture.
- Edge select: 4 full pulses on `signal` (8 edges).
  - `edge_sel`=00 → `count`=4.
  - 01 → `count`=4.
  - 10 → `count`=8.
  - 11 → `count`=0 and no `event_pulse`.
- Wrap vs saturate, WIDTH=4: `load_value`=14, then 3 rising edges counting up.
  - `wrap_en`=1 → `count` sequence 15, 0, 1; `overflow`=1.
  - `wrap_en`=0 → `count` 15, 15, 15; `overflow`=1.
  - `ovf_clear` → `overflow`=0.
- Down count: `count`=2, `up_down`=0, `wrap_en`=1, 3 events → 1, 0, 15 (WIDTH=4); `overflow` sets on the 0→15 step.
- Priority: assert `clear`, `load` (`load_value`=9) and a qualified event in the same cycle → `count`=0 and `event_pulse`=1. Next cycle: `load` and event together → `count`=9. Event arriving with `ovf_clear` at a limit → `overflow` stays 1.
- Match and async reset: `compare_value`=5; count 0→6 → `match` high only while `count`=5. Assert `reset` at `count`=6 mid-cycle → `count`=0 immediately with no `clk` edge.
